bh1750_lux_filter: RTL and testbench

BH1750_LUX_FILTER -- requirements
Module: bh1750_lux_filter

---
 rtl/bh1750_pkg.sv | 16 +
 rtl/bh1750_sample_ring.sv | 39 +++
 rtl/bh1750_lux_filter.sv | 121 ++++++++++++
 tb/tb_bh1750_lux_filter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bh1750_pkg.sv
// Shared types and constants for the BH1750 lux filter.
package bh1750_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_PRELOAD,
    ST_READY,
    ST_UPDATE,
    ST_SCALE
  } state_t;

  localparam int unsigned RAW_W           = 16;
  localparam int unsigned LUX_MUL_DEFAULT = 13654;
  localparam int unsigned Q_SHIFT         = 14;

endpackage

// File: rtl/bh1750_sample_ring.sv
// N x 16 ring of raw samples; the slot at the write pointer is read combinationally.
module bh1750_sample_ring
  import bh1750_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  system_clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [RAW_W-1:0]      wr_data,
  output logic [RAW_W-1:0]      rd_data,
  output logic [DEPTH_LOG2-1:0] wr_ptr,
  output logic                  ptr_last
);

  localparam int unsigned N = 1 << DEPTH_LOG2;

  logic [RAW_W-1:0] mem [N];

  assign rd_data  = mem[wr_ptr];
  assign ptr_last = (wr_ptr == DEPTH_LOG2'(N - 1));

  // Slots are always fully rewritten by preload, so the storage has no reset.
  always_ff @(posedge system_clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge system_clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
    end
  end

endmodule

// File: rtl/bh1750_lux_filter.sv
// Moving-average filter over BH1750 raw counts with lux scaling and a hysteresis flag.
module bh1750_lux_filter
  import bh1750_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned LUX_MUL    = LUX_MUL_DEFAULT,
  parameter int unsigned THR_HI     = 500,
  parameter int unsigned THR_LO     = 300
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        sample_valid,
  input  logic [15:0] sample_raw,
  output logic        sample_ready,
  output logic        lux_valid,
  output logic [15:0] lux_value,
  output logic [15:0] avg_raw,
  output logic        bright,
  output logic [7:0]  drop_count
);

  localparam int unsigned ACC_W = RAW_W + DEPTH_LOG2;

  state_t                  state;
  logic [RAW_W-1:0]        held;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        acc_upd;
  logic [RAW_W-1:0]        slot_old;
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic                    ptr_last;
  logic                    ring_wr;
  logic [RAW_W-1:0]        avg_next;
  logic [31:0]             product;
  logic [31:0]             product_q;
  logic [RAW_W-1:0]        lux_next;

  assign sample_ready = (state == ST_EMPTY) || (state == ST_READY);
  assign ring_wr      = (state == ST_PRELOAD) || (state == ST_UPDATE);

  bh1750_sample_ring #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ring (
    .system_clock(system_clock),
    .reset       (reset),
    .clear       (clear),
    .wr_en       (ring_wr),
    .wr_data     (held),
    .rd_data     (slot_old),
    .wr_ptr      (wr_ptr),
    .ptr_last    (ptr_last)
  );

  // acc always equals the sum of the ring, so the subtraction cannot underflow.
  assign acc_upd   = acc - ACC_W'(slot_old) + ACC_W'(held);
  assign avg_next  = RAW_W'(acc >> DEPTH_LOG2);
  assign product   = 32'(avg_next) * 32'(LUX_MUL);
  assign product_q = product >> Q_SHIFT;
  assign lux_next  = (|product_q[31:16]) ? 16'hFFFF : product_q[15:0];

  always_ff @(posedge system_clock) begin
    if (reset) begin
      state      <= ST_EMPTY;
      held       <= '0;
      acc        <= '0;
      lux_valid  <= 1'b0;
      lux_value  <= '0;
      avg_raw    <= '0;
      bright     <= 1'b0;
      drop_count <= '0;
    end else begin
      lux_valid <= 1'b0;
      if (clear) begin
        state      <= ST_EMPTY;
        acc        <= '0;
        drop_count <= '0;
      end else begin
        if (sample_valid && !sample_ready && drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
        case (state)
          ST_EMPTY: begin
            if (sample_valid) begin
              held  <= sample_raw;
              state <= ST_PRELOAD;
            end
          end
          ST_PRELOAD: begin
            acc <= ACC_W'(held) << DEPTH_LOG2;
            if (ptr_last) begin
              state <= ST_SCALE;
            end
          end
          ST_READY: begin
            if (sample_valid) begin
              held  <= sample_raw;
              state <= ST_UPDATE;
            end
          end
          ST_UPDATE: begin
            acc   <= acc_upd;
            state <= ST_SCALE;
          end
          ST_SCALE: begin
            avg_raw   <= avg_next;
            lux_value <= lux_next;
            lux_valid <= 1'b1;
            if (32'(lux_next) > THR_HI) begin
              bright <= 1'b1;
            end else if (32'(lux_next) < THR_LO) begin
              bright <= 1'b0;
            end
            state <= ST_READY;
          end
          default: state <= ST_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bh1750_lux_filter.sv
// Scoreboard bench for bh1750_lux_filter: driver queues expected outputs, monitor checks each lux_valid.
module tb_bh1750_lux_filter;

  logic        system_clock = 1'b0;
  logic        reset;
  logic        clear;
  logic        sample_valid;
  logic [15:0] sample_raw;
  logic        sample_ready;
  logic        lux_valid;
  logic [15:0] lux_value;
  logic [15:0] avg_raw;
  logic        bright;
  logic [7:0]  drop_count;

  typedef struct {
    logic [15:0] avg;
    logic [15:0] lux;
    logic        br;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   bad    = 0;
  int   pulses = 0;
  int   pushed = 0;
  logic model_bright = 1'b0;

  bh1750_lux_filter dut (
    .system_clock(system_clock),
    .reset       (reset),
    .clear       (clear),
    .sample_valid(sample_valid),
    .sample_raw  (sample_raw),
    .sample_ready(sample_ready),
    .lux_valid   (lux_valid),
    .lux_value   (lux_value),
    .avg_raw     (avg_raw),
    .bright      (bright),
    .drop_count  (drop_count)
  );

  always #5 system_clock = ~system_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_out(input logic [15:0] avg, input logic [15:0] lux, input logic br);
    exp_t e;
    e.avg = avg;
    e.lux = lux;
    e.br  = br;
    exp_q.push_back(e);
    pushed++;
  endtask

  // Reference lux for the ramp: avg * 13654 / 2^14, with the 500/300 hysteresis.
  task automatic expect_model(input logic [15:0] avg);
    logic [31:0] p;
    p = (32'(avg) * 32'd13654) >> 14;
    if (p > 32'd500) model_bright = 1'b1;
    else if (p < 32'd300) model_bright = 1'b0;
    expect_out(avg, p[15:0], model_bright);
  endtask

  always @(negedge system_clock) begin
    if (lux_valid) begin
      exp_t e;
      pulses++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_lux_valid: got lux=%0d avg=%0d, required no pulse", lux_value, avg_raw);
      end else begin
        e = exp_q.pop_front();
        check("sb_avg_raw", 32'(avg_raw), 32'(e.avg));
        check("sb_lux_value", 32'(lux_value), 32'(e.lux));
        check("sb_bright", 32'(bright), 32'(e.br));
      end
    end
  end

  task automatic tick();
    @(posedge system_clock);
    #1;
  endtask

  task automatic send(input logic [15:0] raw);
    sample_valid = 1'b1;
    sample_raw   = raw;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!sample_ready && n < 100) begin
      tick();
      n++;
    end
    if (!sample_ready) check("ready_timeout", 32'(sample_ready), 32'd1);
  endtask

  task automatic do_clear(input logic with_valid);
    clear        = 1'b1;
    sample_valid = with_valid;
    sample_raw   = 16'd777;
    tick();
    clear        = 1'b0;
    sample_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    clear        = 1'b0;
    sample_valid = 1'b0;
    sample_raw   = '0;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_lux_valid", 32'(lux_valid), 32'd0);
    check("rst_lux_value", 32'(lux_value), 32'd0);
    check("rst_avg_raw", 32'(avg_raw), 32'd0);
    check("rst_bright", 32'(bright), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_sample_ready", 32'(sample_ready), 32'd1);

    // Preload with 120: 120*13654>>14 = 100.
    expect_out(16'd120, 16'd100, 1'b0);
    model_bright = 1'b0;
    send(16'd120);
    n = 0;
    while (!sample_ready && n < 50) begin
      tick();
      n++;
    end
    check("preload_busy_cycles", 32'(n), 32'd9);

    // Ramp window from 120 to 1200: avg = 120 + 135*k.
    expect_out(16'd255, 16'd212, 1'b0);
    send(16'd1200);
    wait_ready();
    for (int k = 2; k <= 7; k++) begin
      expect_model(16'(120 + 135 * k));
      send(16'd1200);
      wait_ready();
    end
    expect_out(16'd1200, 16'd1000, 1'b1);
    send(16'd1200);
    wait_ready();
    check("ramp_final_lux", 32'(lux_value), 32'd1000);

    // Valid held through UPDATE and SCALE: one accept, two drops.
    expect_out(16'd1200, 16'd1000, 1'b1);
    sample_valid = 1'b1;
    sample_raw   = 16'd1200;
    repeat (3) tick();
    sample_valid = 1'b0;
    check("drop_count_two", 32'(drop_count), 32'd2);
    for (int i = 0; i < 150; i++) begin
      expect_out(16'd1200, 16'd1000, 1'b1);
      sample_valid = 1'b1;
      repeat (3) tick();
      sample_valid = 1'b0;
    end
    check("drop_count_sat", 32'(drop_count), 32'd255);

    // Clear with simultaneous valid: no drop, no capture, outputs retained.
    tick();
    do_clear(1'b1);
    check("clear_drop_zero", 32'(drop_count), 32'd0);
    check("clear_ready", 32'(sample_ready), 32'd1);
    check("clear_keeps_lux", 32'(lux_value), 32'd1000);
    check("clear_keeps_bright", 32'(bright), 32'd1);

    // Hysteresis: 480 -> 400 lux, 300 -> 250 lux.
    expect_out(16'd480, 16'd400, 1'b1);
    send(16'd480);
    wait_ready();
    do_clear(1'b0);
    expect_out(16'd300, 16'd250, 1'b0);
    send(16'd300);
    wait_ready();
    do_clear(1'b0);
    expect_out(16'd480, 16'd400, 1'b0);
    send(16'd480);
    wait_ready();

    // Full-scale preload: (65535*13654)>>14 = 54615, no accumulator wrap.
    do_clear(1'b0);
    expect_out(16'hFFFF, 16'd54615, 1'b1);
    send(16'hFFFF);
    wait_ready();

    // Clear during UPDATE aborts with no pulse.
    tick();
    send(16'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_ready", 32'(sample_ready), 32'd1);
    check("abort_lux_kept", 32'(lux_value), 32'd54615);
    repeat (6) tick();
    check("abort_lux_still", 32'(lux_value), 32'd54615);

    // Reset during PRELOAD wins over clear and valid.
    send(16'd500);
    repeat (3) tick();
    reset        = 1'b1;
    clear        = 1'b1;
    sample_valid = 1'b1;
    tick();
    reset        = 1'b0;
    clear        = 1'b0;
    sample_valid = 1'b0;
    check("rst2_lux_value", 32'(lux_value), 32'd0);
    check("rst2_avg_raw", 32'(avg_raw), 32'd0);
    check("rst2_bright", 32'(bright), 32'd0);
    check("rst2_ready", 32'(sample_ready), 32'd1);
    repeat (12) tick();

    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    check("pulse_count", 32'(pulses), 32'(pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
